// File: rtl/fp_pair_sum_ctrl.sv
// fp_pair_sum_ctrl
// Master-side sequencer for the operand path: reads ROM word pairs (2k, 2k+1), feeds them to a
// passive multi-cycle adder, and writes each sum to RAM[k]. When idle, a host can read a RAM
// word back through a request/valid port. Every output is a register.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           begin a run (sampled in idle only)
//   busy_o, done_o    run in progress / one-cycle completion pulse
//   rom_addr_o/oe_o   ROM address and output enable; rom_data_i is combinational read data
//   add_op1/2_o       adder operands, add_en_o adder enable, add_sum_i adder result
//   ram_addr_o        RAM word address
//   ram_rw_o          RAM write strobe (level-sensitive)
//   ram_oe_o          RAM read enable
//   ram_wdata_o       RAM write data
//   ram_rdata_i       RAM read data (combinational)
//   rd_req_i          host readback request (sampled in idle when start_i is low)
//   rd_addr_i         host readback address
//   rd_valid_o        one-cycle pulse marking rd_data_o valid
//   rd_data_o         readback data
module fp_pair_sum_ctrl #(
    parameter int unsigned NPAIRS  = 4,
    parameter int unsigned ADD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [2:0]  rom_addr_o,
    output logic        rom_oe_o,
    input  logic [31:0] rom_data_i,
    output logic [31:0] add_op1_o,
    output logic [31:0] add_op2_o,
    output logic        add_en_o,
    input  logic [31:0] add_sum_i,
    output logic [1:0]  ram_addr_o,
    output logic        ram_rw_o,
    output logic        ram_oe_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i,
    input  logic        rd_req_i,
    input  logic [1:0]  rd_addr_i,
    output logic        rd_valid_o,
    output logic [31:0] rd_data_o
);

    localparam int unsigned LatW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    typedef enum logic [3:0] {
        StIdle, StFetchA, StFetchB, StLatchB, StAdd,
        StWrSetup, StWr, StWrHold, StRd, StRdOut
    } state_e;

    state_e            state_q;
    logic [1:0]        k_q;
    logic [LatW-1:0]   lat_cnt_q;
    logic              busy_q, done_q, rom_oe_q, add_en_q, ram_rw_q, ram_oe_q, rd_valid_q;
    logic [2:0]        rom_addr_q;
    logic [1:0]        ram_addr_q;
    logic [31:0]       add_op1_q, add_op2_q, ram_wdata_q, rd_data_q;

    // Outputs are set on the edge that enters a state, so each state's outputs are stable for
    // the whole time the FSM sits in it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            k_q         <= '0;
            lat_cnt_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rom_oe_q    <= 1'b0;
            add_en_q    <= 1'b0;
            ram_rw_q    <= 1'b0;
            ram_oe_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rom_addr_q  <= '0;
            ram_addr_q  <= '0;
            add_op1_q   <= '0;
            add_op2_q   <= '0;
            ram_wdata_q <= '0;
            rd_data_q   <= '0;
        end else begin
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q    <= StFetchA;
                        k_q        <= '0;
                        busy_q     <= 1'b1;
                        rom_addr_q <= 3'd0;
                        rom_oe_q   <= 1'b1;
                    end else if (rd_req_i) begin
                        state_q    <= StRd;
                        ram_addr_q <= rd_addr_i;
                        ram_rw_q   <= 1'b0;
                        ram_oe_q   <= 1'b1;
                    end
                end
                StFetchA: begin
                    add_op1_q  <= rom_data_i;
                    rom_addr_q <= {k_q, 1'b1};
                    state_q    <= StFetchB;
                end
                StFetchB: begin
                    add_op2_q <= rom_data_i;
                    rom_oe_q  <= 1'b0;
                    state_q   <= StLatchB;
                end
                StLatchB: begin
                    add_en_q  <= 1'b1;
                    lat_cnt_q <= '0;
                    state_q   <= StAdd;
                end
                StAdd: begin
                    if (lat_cnt_q == LatW'(ADD_LAT - 1)) begin
                        ram_wdata_q <= add_sum_i;
                        ram_addr_q  <= k_q;
                        ram_rw_q    <= 1'b0;
                        add_en_q    <= 1'b0;
                        state_q     <= StWrSetup;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + LatW'(1);
                    end
                end
                StWrSetup: begin
                    ram_rw_q <= 1'b1;
                    state_q  <= StWr;
                end
                StWr: begin
                    ram_rw_q <= 1'b0;
                    state_q  <= StWrHold;
                end
                StWrHold: begin
                    if (k_q != 2'(NPAIRS - 1)) begin
                        k_q        <= k_q + 2'd1;
                        rom_addr_q <= {k_q + 2'd1, 1'b0};
                        rom_oe_q   <= 1'b1;
                        state_q    <= StFetchA;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                StRd: begin
                    rd_data_q  <= ram_rdata_i;
                    rd_valid_q <= 1'b1;
                    ram_oe_q   <= 1'b0;
                    state_q    <= StRdOut;
                end
                StRdOut: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign rom_addr_o  = rom_addr_q;
    assign rom_oe_o    = rom_oe_q;
    assign add_op1_o   = add_op1_q;
    assign add_op2_o   = add_op2_q;
    assign add_en_o    = add_en_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_rw_o    = ram_rw_q;
    assign ram_oe_o    = ram_oe_q;
    assign ram_wdata_o = ram_wdata_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;

endmodule

// File: tb/tb_fp_pair_sum_ctrl.sv
// Bench for fp_pair_sum_ctrl: instance 0 uses the default parameters and carries the scoreboard;
// instances 1 and 2 (NPAIRS=1 with ADD_LAT=1 and ADD_LAT=4) share the same stimulus.
module tb_fp_pair_sum_ctrl;

    logic clk, rst_n, start, rd_req;
    logic [1:0] rd_addr;

    logic        busy [3], done [3], rom_oe [3], add_en [3], ram_rw [3], ram_oe [3], rd_valid [3];
    logic [2:0]  rom_addr [3];
    logic [1:0]  ram_addr [3];
    logic [31:0] rom_data [3], add_op1 [3], add_op2 [3], add_sum [3];
    logic [31:0] ram_wdata [3], ram_rdata [3], rd_data [3];

    function automatic logic [31:0] rom_word(input logic [2:0] a);
        case (a)
            3'd0: rom_word = 32'h0986ab68;
            3'd1: rom_word = 32'h10385ba9;
            3'd2: rom_word = 32'h3F800000;
            3'd3: rom_word = 32'h3C449BA6;
            3'd4: rom_word = 32'h40400000;
            3'd5: rom_word = 32'h41200000;
            3'd6: rom_word = 32'h3EA00000;
            default: rom_word = 32'h3F600000;
        endcase
    endfunction

    function automatic int al_of(input int g);
        al_of = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned NP = (g == 0) ? 4 : 1;
        localparam int unsigned AL = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        int unsigned en_cnt;
        logic [31:0] mem [4];

        fp_pair_sum_ctrl #(.NPAIRS(NP), .ADD_LAT(AL)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .start_i     (start),
            .busy_o      (busy[g]),
            .done_o      (done[g]),
            .rom_addr_o  (rom_addr[g]),
            .rom_oe_o    (rom_oe[g]),
            .rom_data_i  (rom_data[g]),
            .add_op1_o   (add_op1[g]),
            .add_op2_o   (add_op2[g]),
            .add_en_o    (add_en[g]),
            .add_sum_i   (add_sum[g]),
            .ram_addr_o  (ram_addr[g]),
            .ram_rw_o    (ram_rw[g]),
            .ram_oe_o    (ram_oe[g]),
            .ram_wdata_o (ram_wdata[g]),
            .ram_rdata_i (ram_rdata[g]),
            .rd_req_i    (rd_req),
            .rd_addr_i   (rd_addr),
            .rd_valid_o  (rd_valid[g]),
            .rd_data_o   (rd_data[g])
        );

        assign rom_data[g] = rom_oe[g] ? rom_word(rom_addr[g]) : 32'hBAD0_BAD0;

        // Adder stub: the sum is only presented in the ADD_LAT-th consecutive enabled cycle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) en_cnt <= 0;
            else        en_cnt <= add_en[g] ? en_cnt + 1 : 0;
        end
        assign add_sum[g] = (add_en[g] && en_cnt == AL - 1) ? add_op1[g] + add_op2[g]
                                                            : 32'hDEAD_BEEF;

        always_ff @(posedge clk) begin
            if (ram_rw[g]) mem[ram_addr[g]] <= ram_wdata[g];
        end
        assign ram_rdata[g] = ram_oe[g] ? mem[ram_addr[g]] : 32'hBAD1_BAD1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] a; logic [31:0] b; } pair_t;
    typedef struct packed { logic [1:0] addr; logic [31:0] data; } wr_t;
    pair_t op_q [$];
    wr_t   wr_q [$];
    logic [31:0] cur_a, cur_b;

    int vecs, errs;
    int busy_len [3], last_len [3], done_cnt [3], en_len [3], en_bad [3], en_pairs [3];
    int wr_cnt [3], oe_cnt [3], rdv_cnt [3];
    int proto_bad, excl_bad;
    logic [3:0]  wr_mask [3];
    logic        prev_rw [3];
    logic [1:0]  prev_addr [3];
    logic [31:0] prev_wdata [3];
    logic        prev_en0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vecs++;
        assert (got === want) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic push_run();
        for (int k = 0; k < 4; k++) begin
            pair_t p;
            wr_t   w;
            p.a = rom_word(3'(2 * k));
            p.b = rom_word(3'(2 * k + 1));
            w.addr = 2'(k);
            w.data = p.a + p.b;
            op_q.push_back(p);
            wr_q.push_back(w);
        end
    endtask

    task automatic clear_trackers();
        for (int g = 0; g < 3; g++) begin
            busy_len[g] = 0; en_len[g] = 0;
            prev_rw[g] = 1'b0; prev_addr[g] = '0; prev_wdata[g] = '0;
        end
        prev_en0 = 1'b0;
    endtask

    // Advance one cycle, sample 1ns after the edge, and update monitors and the scoreboard.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            if (busy[g]) busy_len[g]++;
            else begin
                if (done[g]) begin
                    last_len[g] = busy_len[g];
                    done_cnt[g]++;
                end
                busy_len[g] = 0;
            end
            if (add_en[g]) en_len[g]++;
            else if (en_len[g] != 0) begin
                if (en_len[g] != al_of(g)) en_bad[g]++;
                en_pairs[g]++;
                en_len[g] = 0;
            end
            if (ram_rw[g] && !prev_rw[g]) begin
                wr_cnt[g]++;
                wr_mask[g][ram_addr[g]] = 1'b1;
                if (g != 0) chk("sweep_wdata", ram_wdata[g], 32'h19BF0711);
            end
            if ((ram_rw[g] || prev_rw[g]) &&
                (ram_addr[g] != prev_addr[g] || ram_wdata[g] != prev_wdata[g])) proto_bad++;
            if ((rom_oe[g] && ram_oe[g]) || (ram_oe[g] && ram_rw[g])) excl_bad++;
            if (ram_oe[g]) oe_cnt[g]++;
            if (rd_valid[g]) rdv_cnt[g]++;
        end
        if (add_en[0] && !prev_en0) begin
            chk("op_q_nonempty", 32'(op_q.size() > 0), 32'd1);
            if (op_q.size() > 0) begin
                pair_t p;
                p = op_q.pop_front();
                cur_a = p.a;
                cur_b = p.b;
                chk("add_op1", add_op1[0], cur_a);
                chk("add_op2", add_op2[0], cur_b);
            end
        end else if (add_en[0]) begin
            chk("add_op1_hold", add_op1[0], cur_a);
            chk("add_op2_hold", add_op2[0], cur_b);
        end
        if (ram_rw[0] && !prev_rw[0]) begin
            chk("wr_q_nonempty", 32'(wr_q.size() > 0), 32'd1);
            if (wr_q.size() > 0) begin
                wr_t w;
                w = wr_q.pop_front();
                chk("ram_addr", 32'(ram_addr[0]), 32'(w.addr));
                chk("ram_wdata", ram_wdata[0], w.data);
            end
        end
        for (int g = 0; g < 3; g++) begin
            prev_rw[g] = ram_rw[g];
            prev_addr[g] = ram_addr[g];
            prev_wdata[g] = ram_wdata[g];
        end
        prev_en0 = add_en[0];
    endtask

    task automatic wait_done(input int max_cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (done[0]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_within_bound", 32'(seen), 32'd1);
    endtask

    task automatic rd_check(input logic [1:0] a, input logic [31:0] want);
        int oe0;
        oe0 = oe_cnt[0];
        rd_addr = a;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("rd_oe_in_rd", 32'(ram_oe[0]), 32'd1);
        chk("rd_valid_early", 32'(rd_valid[0]), 32'd0);
        tick();
        chk("rd_valid", 32'(rd_valid[0]), 32'd1);
        chk("rd_data", rd_data[0], want);
        chk("rd_oe_off", 32'(ram_oe[0]), 32'd0);
        tick();
        chk("rd_valid_pulse", 32'(rd_valid[0]), 32'd0);
        chk("rd_oe_cycles", 32'(oe_cnt[0] - oe0), 32'd1);
    endtask

    initial begin
        int dc, rdv, ep, wc, oe0;
        logic hit;
        vecs = 0; errs = 0; proto_bad = 0; excl_bad = 0;
        for (int g = 0; g < 3; g++) begin
            last_len[g] = 0; done_cnt[g] = 0; en_bad[g] = 0; en_pairs[g] = 0;
            wr_cnt[g] = 0; oe_cnt[g] = 0; rdv_cnt[g] = 0; wr_mask[g] = '0;
        end
        clear_trackers();
        cur_a = '0; cur_b = '0;
        rst_n = 1'b0; start = 1'b0; rd_req = 1'b0; rd_addr = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("rst_ctrl", 32'({busy[g], done[g], rom_oe[g], add_en[g], ram_rw[g], ram_oe[g],
                                 rd_valid[g]}), 32'd0);
            chk("rst_addrs", 32'({rom_addr[g], ram_addr[g]}), 32'd0);
            chk("rst_ops", add_op1[g] | add_op2[g], 32'd0);
            chk("rst_data", ram_wdata[g] | rd_data[g], 32'd0);
        end
        rst_n = 1'b1;
        repeat (2) tick();

        // Full default run
        ep = en_pairs[0]; wc = wr_cnt[0]; oe0 = oe_cnt[0];
        push_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_rise", 32'(busy[0]), 32'd1);
        wait_done(100);
        chk("busy_len_default", 32'(last_len[0]), 32'd32);
        repeat (3) tick();
        chk("done_once", 32'(done_cnt[0]), 32'd1);
        chk("run_wr_pulses", 32'(wr_cnt[0] - wc), 32'd4);
        chk("run_add_pairs", 32'(en_pairs[0] - ep), 32'd4);
        chk("run_no_ram_oe", 32'(oe_cnt[0] - oe0), 32'd0);
        chk("sb_empty_ops", 32'(op_q.size()), 32'd0);
        chk("sb_empty_wr", 32'(wr_q.size()), 32'd0);
        chk("sw1_busy_len", 32'(last_len[1]), 32'd7);
        chk("sw2_busy_len", 32'(last_len[2]), 32'd10);
        chk("sw1_pairs", 32'(en_pairs[1]), 32'd1);
        chk("sw2_pairs", 32'(en_pairs[2]), 32'd1);
        chk("sw1_wr_mask", 32'(wr_mask[1]), 32'h1);
        chk("sw2_wr_mask", 32'(wr_mask[2]), 32'h1);

        // Readback
        rd_check(2'd2, 32'h81600000);
        rd_check(2'd3, 32'h7E000000);
        rd_check(2'd0, 32'h19BF0711);

        // start and rd_req together, then a start pulse while busy
        rdv = rdv_cnt[0]; dc = done_cnt[0];
        push_run();
        rd_addr = 2'd1; start = 1'b1; rd_req = 1'b1;
        tick();
        start = 1'b0; rd_req = 1'b0;
        chk("prio_busy", 32'(busy[0]), 32'd1);
        chk("prio_no_rd_oe", 32'(ram_oe[0]), 32'd0);
        repeat (5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(100);
        chk("busy_len_ignore", 32'(last_len[0]), 32'd32);
        chk("single_done", 32'(done_cnt[0] - dc), 32'd1);
        chk("prio_no_rd_valid", 32'(rdv_cnt[0] - rdv), 32'd0);

        // Restart in the cycle right after done, then reset during the first write
        push_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_busy", 32'(busy[0]), 32'd1);
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ram_rw[0]) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        chk("reach_wr", 32'(hit), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_rw", 32'(ram_rw[0]), 32'd0);
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        chk("midrst_done", 32'(done[0]), 32'd0);
        op_q.delete();
        wr_q.delete();
        clear_trackers();
        wc = wr_cnt[0];
        repeat (2) tick();
        chk("rst_no_write", 32'(wr_cnt[0] - wc), 32'd0);
        rst_n = 1'b1;
        tick();

        // Fresh run after reset starts from pair 0
        push_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(100);
        chk("busy_len_after_rst", 32'(last_len[0]), 32'd32);
        chk("sb_empty_wr_final", 32'(wr_q.size()), 32'd0);
        rd_check(2'd1, 32'h7BC49BA6);

        chk("wr_protocol", 32'(proto_bad), 32'd0);
        chk("oe_exclusive", 32'(excl_bad), 32'd0);
        for (int g = 0; g < 3; g++) chk("add_en_len", 32'(en_bad[g]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
